// File: rtl/cdp_dp_cvtout_unit.sv
// CDP output converter: round/shift stage, then saturate stage.
// Also keeps a sticky count of saturated lanes.
module cdp_dp_cvtout_unit (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        mul_unit_vld,
  output logic        mul_unit_rdy,
  input  logic [49:0] mul_unit_pd,
  input  logic [1:0]  reg2dp_input_data_type,
  input  logic [5:0]  reg2dp_datout_shifter,
  input  logic        reg2dp_op_en,
  output logic        cvtout_pvld,
  input  logic        cvtout_prdy,
  output logic [15:0] cvtout_pd,
  output logic [31:0] dp2reg_sat_cnt
);

  typedef enum logic [1:0] {
    M_I8  = 2'd0,
    M_I16 = 2'd1,
    M_FP  = 2'd2
  } mode_t;

  mode_t              w_mode;
  logic [4:0]         w_sh;
  logic signed [34:0] w_x0;
  logic signed [34:0] w_x1;
  logic signed [34:0] w_rnd;
  logic signed [34:0] w_sum0;
  logic signed [34:0] w_sum1;
  logic signed [34:0] w_r0;
  logic signed [34:0] w_r1;

  logic               r_s1_vld;
  mode_t              r_s1_mode;
  logic signed [33:0] r_s1_r0;
  logic signed [25:0] r_s1_r1;

  logic               r_s2_vld;
  logic [15:0]        r_s2_pd;
  logic [31:0]        r_sat_cnt;
  logic               r_op_en_d;

  logic               w_s1_ld;
  logic               w_s2_ld;
  logic               w_s2_rdy;
  logic               w_clr;
  logic [1:0]         w_sat;
  logic [1:0]         w_inc;
  logic [32:0]        w_cnt_sum;
  logic [15:0]        w_s2_pd;
  logic [7:0]         w_q0;
  logic [7:0]         w_q1;
  logic [15:0]        w_q16;

  always_comb begin
    w_mode = M_I16;
    unique case (reg2dp_input_data_type)
      2'd0:    w_mode = M_I8;
      2'd2:    w_mode = M_FP;
      default: w_mode = M_I16;
    endcase
  end

  assign w_sh = (reg2dp_datout_shifter > 6'd31) ? 5'd31
              : reg2dp_datout_shifter[4:0];

  // 35b headroom keeps the rounding add exact for every shift value
  assign w_x0 = (w_mode == M_I8)
              ? {{10{mul_unit_pd[24]}}, mul_unit_pd[24:0]}
              : {{2{mul_unit_pd[32]}}, mul_unit_pd[32:0]};
  assign w_x1 = {{10{mul_unit_pd[49]}}, mul_unit_pd[49:25]};

  assign w_rnd  = (w_sh == 5'd0) ? 35'sd0
                : (35'sd1 <<< (w_sh - 5'd1));
  assign w_sum0 = w_x0 + w_rnd;
  assign w_sum1 = w_x1 + w_rnd;
  assign w_r0   = w_sum0 >>> w_sh;
  assign w_r1   = w_sum1 >>> w_sh;

  assign w_s2_rdy     = ~r_s2_vld | cvtout_prdy;
  assign mul_unit_rdy = ~r_s1_vld | w_s2_rdy;
  assign w_s1_ld      = mul_unit_vld & mul_unit_rdy;
  assign w_s2_ld      = r_s1_vld & w_s2_rdy;

  assign w_q0 = (r_s1_r0 > 34'sd127)  ? 8'h7F
              : (r_s1_r0 < -34'sd128) ? 8'h80
              : r_s1_r0[7:0];
  assign w_q1 = (r_s1_r1 > 26'sd127)  ? 8'h7F
              : (r_s1_r1 < -26'sd128) ? 8'h80
              : r_s1_r1[7:0];
  assign w_q16 = (r_s1_r0 > 34'sd32767)  ? 16'h7FFF
               : (r_s1_r0 < -34'sd32768) ? 16'h8000
               : r_s1_r0[15:0];

  always_comb begin
    w_s2_pd = '0;
    w_sat   = '0;
    unique case (r_s1_mode)
      M_I8: begin
        w_s2_pd  = {w_q1, w_q0};
        w_sat[0] = (r_s1_r0 > 34'sd127) | (r_s1_r0 < -34'sd128);
        w_sat[1] = (r_s1_r1 > 26'sd127) | (r_s1_r1 < -26'sd128);
      end
      M_I16: begin
        w_s2_pd  = w_q16;
        w_sat[0] = (r_s1_r0 > 34'sd32767)
                 | (r_s1_r0 < -34'sd32768);
      end
      default: w_s2_pd = r_s1_r0[15:0];
    endcase
  end

  assign w_inc     = {1'b0, w_sat[1]} + {1'b0, w_sat[0]};
  assign w_cnt_sum = {1'b0, r_sat_cnt} + {31'd0, w_inc};
  assign w_clr     = reg2dp_op_en & ~r_op_en_d;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s1_vld  <= 1'b0;
      r_s1_mode <= M_I8;
      r_s1_r0   <= '0;
      r_s1_r1   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_pd   <= '0;
      r_sat_cnt <= '0;
      r_op_en_d <= 1'b0;
    end else begin
      r_op_en_d <= reg2dp_op_en;
      if (w_s1_ld) begin
        r_s1_vld  <= 1'b1;
        r_s1_mode <= w_mode;
        r_s1_r0   <= (w_mode == M_FP) ? {18'd0, mul_unit_pd[15:0]}
                   : w_r0[33:0];
        r_s1_r1   <= w_r1[25:0];
      end else if (w_s2_ld) begin
        r_s1_vld  <= 1'b0;
      end
      if (w_s2_ld) begin
        r_s2_vld <= 1'b1;
        r_s2_pd  <= w_s2_pd;
      end else if (cvtout_prdy) begin
        r_s2_vld <= 1'b0;
      end
      if (w_clr) begin
        r_sat_cnt <= '0;
      end else if (w_s2_ld) begin
        r_sat_cnt <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
      end
    end
  end

  assign cvtout_pvld    = r_s2_vld;
  assign cvtout_pd      = r_s2_pd;
  assign dp2reg_sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_cdp_dp_cvtout_unit.sv
// Bench for cdp_dp_cvtout_unit: directed cases plus random
// traffic scored against an integer reference model.
module tb_cdp_dp_cvtout_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mul_unit_vld;
  logic        mul_unit_rdy;
  logic [49:0] mul_unit_pd;
  logic [1:0]  reg2dp_input_data_type;
  logic [5:0]  reg2dp_datout_shifter;
  logic        reg2dp_op_en;
  logic        cvtout_pvld;
  logic        cvtout_prdy;
  logic [15:0] cvtout_pd;
  logic [31:0] dp2reg_sat_cnt;

  always #5 clk = ~clk;

  cdp_dp_cvtout_unit dut (
    .nvdla_core_clk         (clk),
    .nvdla_core_rstn        (rst_n),
    .mul_unit_vld           (mul_unit_vld),
    .mul_unit_rdy           (mul_unit_rdy),
    .mul_unit_pd            (mul_unit_pd),
    .reg2dp_input_data_type (reg2dp_input_data_type),
    .reg2dp_datout_shifter  (reg2dp_datout_shifter),
    .reg2dp_op_en           (reg2dp_op_en),
    .cvtout_pvld            (cvtout_pvld),
    .cvtout_prdy            (cvtout_prdy),
    .cvtout_pd              (cvtout_pd),
    .dp2reg_sat_cnt         (dp2reg_sat_cnt)
  );

  typedef struct {
    logic [15:0] pd;
    int          acc;
  } beat_t;

  beat_t             q[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                cyc = 0;
  bit                g_lat;
  logic [15:0]       g_last;
  longint unsigned   exp_cnt;
  logic              o_rdy_s;
  logic              o_vld_s;
  logic [15:0]       o_pd_s;
  bit                acc_s;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint rsh(input longint x, input int s);
    if (s == 0) return x;
    return (x + (longint'(1) << (s - 1))) >>> s;
  endfunction

  function automatic void model(input logic [49:0] d,
                                input logic [1:0] ty,
                                input logic [5:0] sh,
                                output logic [15:0] o,
                                output int ns);
    int     s;
    longint a;
    longint b;
    s  = (sh > 6'd31) ? 31 : int'(sh);
    ns = 0;
    o  = '0;
    if (ty == 2'd2) begin
      o = d[15:0];
    end else if (ty == 2'd0) begin
      a = rsh(longint'($signed(d[24:0])), s);
      b = rsh(longint'($signed(d[49:25])), s);
      if (a > 127) begin a = 127; ns++; end
      else if (a < -128) begin a = -128; ns++; end
      if (b > 127) begin b = 127; ns++; end
      else if (b < -128) begin b = -128; ns++; end
      o = {b[7:0], a[7:0]};
    end else begin
      a = rsh(longint'($signed(d[32:0])), s);
      if (a > 32767) begin a = 32767; ns++; end
      else if (a < -32768) begin a = -32768; ns++; end
      o = a[15:0];
    end
  endfunction

  function automatic int rval(input int m);
    if (m == 0) return int'($urandom);
    if (m == 1) return int'($urandom_range(0, 800)) - 400;
    return int'($urandom_range(0, 140000)) - 70000;
  endfunction

  function automatic logic [49:0] gen(input logic [1:0] ty);
    logic [24:0] a;
    logic [24:0] b;
    logic [32:0] p;
    a = 25'(rval(int'($urandom % 3)));
    b = 25'(rval(int'($urandom % 3)));
    if ($urandom % 2 == 0) p = {1'($urandom), 32'($urandom)};
    else p = 33'(int'($urandom_range(0, 600000)) - 300000);
    if (ty == 2'd0) return {b, a};
    if (ty == 2'd2) return {34'($urandom), 16'($urandom)};
    return {{17{p[32]}}, p};
  endfunction

  task automatic step(input bit v, input logic [49:0] d,
                      input logic [1:0] ty, input logic [5:0] sh,
                      input bit pr);
    logic [15:0] o;
    int          ns;
    beat_t       bt;
    mul_unit_vld           = v;
    mul_unit_pd            = d;
    reg2dp_input_data_type = ty;
    reg2dp_datout_shifter  = sh;
    cvtout_prdy            = pr;
    #1;
    o_rdy_s = mul_unit_rdy;
    o_vld_s = cvtout_pvld;
    o_pd_s  = cvtout_pd;
    acc_s   = v && mul_unit_rdy;
    if (cvtout_pvld && pr) begin
      if (q.size() == 0) begin
        chk("spurious", 64'(cvtout_pvld), 64'd0);
      end else begin
        bt = q.pop_front();
        chk("pd", 64'(cvtout_pd), 64'(bt.pd));
        if (g_lat) chk("lat", 64'(cyc - bt.acc), 64'd2);
        g_last = cvtout_pd;
      end
    end
    if (acc_s) begin
      model(d, ty, sh, o, ns);
      q.push_back('{o, cyc});
      exp_cnt = exp_cnt + longint'(ns);
      if (exp_cnt > 64'hFFFF_FFFF) exp_cnt = 64'hFFFF_FFFF;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(1'b0, '0, 2'd0, 6'd0, 1'b1);
    chk("drain_q", 64'(q.size()), 64'd0);
    chk("drain_vld", 64'(cvtout_pvld), 64'd0);
  endtask

  task automatic send(input logic [49:0] d, input logic [1:0] ty,
                      input logic [5:0] sh);
    int k;
    k = 0;
    do begin
      step(1'b1, d, ty, sh, 1'b1);
      k++;
    end while (!acc_s && k < 20);
    chk("send_acc", 64'(acc_s), 64'd1);
  endtask

  logic [49:0] d;
  logic [24:0] l0;
  logic [24:0] l1;
  logic [32:0] p33;
  logic [49:0] satb;
  logic [49:0] bp[4];
  logic [15:0] held;

  initial begin
    int na;
    int nb;
    int k;
    bit seen;
    logic [1:0] ty;
    logic [5:0] sh;
    rst_n                  = 1'b0;
    mul_unit_vld           = 1'b0;
    mul_unit_pd            = '0;
    reg2dp_input_data_type = 2'd0;
    reg2dp_datout_shifter  = 6'd0;
    reg2dp_op_en           = 1'b1;
    cvtout_prdy            = 1'b1;
    exp_cnt                = 0;
    g_lat                  = 1'b1;
    g_last                 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", 64'(cvtout_pvld), 64'd0);
    chk("rst_pd", 64'(cvtout_pd), 64'd0);
    chk("rst_cnt", 64'(dp2reg_sat_cnt), 64'd0);
    chk("rst_rdy", 64'(mul_unit_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    l0 = 25'd300;
    l1 = -25'sd1000;
    send({l1, l0}, 2'd0, 6'd2);
    drain();
    chk("i8_pd", 64'(g_last), 64'h804B);
    chk("i8_cnt", 64'(dp2reg_sat_cnt), 64'd1);

    d = 50'd74565;
    send(d, 2'd1, 6'd3);
    drain();
    chk("i16_s3", 64'(g_last), 64'h2469);
    chk("i16_s3_cnt", 64'(dp2reg_sat_cnt), 64'd1);
    send(d, 2'd1, 6'd1);
    drain();
    chk("i16_s1", 64'(g_last), 64'h7FFF);
    chk("i16_s1_cnt", 64'(dp2reg_sat_cnt), 64'd2);
    p33 = -33'sd3;
    send({{17{1'b1}}, p33}, 2'd1, 6'd1);
    drain();
    chk("i16_tie", 64'(g_last), 64'hFFFF);
    send({{17{1'b1}}, p33}, 2'd3, 6'd1);
    drain();
    chk("ty3_tie", 64'(g_last), 64'hFFFF);
    send({34'h3_0000_1234, 16'h3C00}, 2'd2, 6'd5);
    drain();
    chk("fp_pd", 64'(g_last), 64'h3C00);
    chk("fp_cnt", 64'(dp2reg_sat_cnt), 64'd2);

    g_lat = 1'b0;
    for (int i = 0; i < 4; i++) bp[i] = gen(2'd0);
    na = 0;
    seen = 1'b0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      nb = na;
      step(1'b1, bp[na], 2'd0, 6'd2, 1'b0);
      if (acc_s) na++;
      chk("bp_rdy", 64'(o_rdy_s), 64'(nb < 2));
      if (o_vld_s) begin
        if (!seen) begin
          held = o_pd_s;
          seen = 1'b1;
        end else begin
          chk("bp_hold", 64'(o_pd_s), 64'(held));
        end
      end
    end
    chk("bp_acc2", 64'(na), 64'd2);
    k = 0;
    while (na < 4 && k < 20) begin
      step(1'b1, bp[na], 2'd0, 6'd2, 1'b1);
      if (acc_s) na++;
      k++;
    end
    drain();
    chk("bp_n", 64'(na), 64'd4);
    chk("bp_cnt", 64'(dp2reg_sat_cnt), 64'(exp_cnt));

    l0 = 25'd100000;
    l1 = -25'sd100000;
    satb = {l1, l0};
    force dut.r_sat_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_sat_cnt;
    exp_cnt = 64'hFFFF_FFFE;
    send(satb, 2'd0, 6'd0);
    drain();
    chk("stick1", 64'(dp2reg_sat_cnt), 64'hFFFF_FFFF);
    send(satb, 2'd0, 6'd0);
    drain();
    chk("stick2", 64'(dp2reg_sat_cnt), 64'hFFFF_FFFF);

    reg2dp_op_en = 1'b0;
    step(1'b0, '0, 2'd0, 6'd0, 1'b1);
    step(1'b1, satb, 2'd0, 6'd0, 1'b1);
    chk("clr_acc", 64'(acc_s), 64'd1);
    reg2dp_op_en = 1'b1;
    step(1'b0, '0, 2'd0, 6'd0, 1'b1);
    exp_cnt = 0;
    drain();
    chk("clr_win", 64'(dp2reg_sat_cnt), 64'd0);
    send(satb, 2'd0, 6'd0);
    drain();
    chk("clr_after", 64'(dp2reg_sat_cnt), 64'd2);

    for (int ph = 0; ph < 3; ph++) begin
      g_lat = (ph == 0);
      for (int c = 0; c < 400; c++) begin
        ty = 2'($urandom % 4);
        sh = ($urandom % 4 == 0) ? 6'($urandom % 64)
                                 : 6'($urandom % 8);
        case (ph)
          0: step(1'b1, gen(ty), ty, sh, 1'b1);
          1: step($urandom % 10 < 7, gen(ty), ty, sh,
                  $urandom % 10 < 6);
          default: step($urandom % 10 < 9, gen(ty), ty, sh,
                        $urandom % 10 < 3);
        endcase
      end
      drain();
      chk("rnd_cnt", 64'(dp2reg_sat_cnt), 64'(exp_cnt));
    end

    g_lat = 1'b0;
    step(1'b1, satb, 2'd0, 6'd0, 1'b0);
    step(1'b1, satb, 2'd0, 6'd0, 1'b0);
    mul_unit_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 64'(cvtout_pvld), 64'd0);
    chk("mrst_cnt", 64'(dp2reg_sat_cnt), 64'd0);
    chk("mrst_rdy", 64'(mul_unit_rdy), 64'd1);
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 2'd0, 6'd0, 1'b1);
      if (o_vld_s) nb++;
    end
    chk("mrst_stale", 64'(nb), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
